// File: rtl/pfvf_req_router.sv
// PF/VF/VA request router: table decode, one holding stage, timeout drop
// and saturating error counters.
module pfvf_req_router #(
   parameter int NUM_PORTS = 8,
   parameter int DATA_W    = 64,
   parameter int PF_W      = 3,
   parameter int VF_W      = 11,
   parameter logic [NUM_PORTS-1:0][PF_W-1:0] PORT_PF =
      {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0},
   parameter logic [NUM_PORTS-1:0][VF_W-1:0] PORT_VF =
      {11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd1, 11'd2},
   parameter logic [NUM_PORTS-1:0] PORT_VA = 8'b0000_0111,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PF_W-1:0]      in_pf,
   input  logic [VF_W-1:0]      in_vf,
   input  logic                 in_va,
   input  logic [DATA_W-1:0]    in_data,
   output logic [NUM_PORTS:0]   out_valid,
   input  logic [NUM_PORTS:0]   out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [15:0]          unmatched_cnt,
   output logic [15:0]          timeout_cnt,
   output logic                 err_sticky,
   input  logic                 err_clr
);

   localparam int DW = $clog2(NUM_PORTS + 1);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic TO_EN = (TIMEOUT != 0);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [DW-1:0] DEF_PORT = DW'(NUM_PORTS);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     dest_q;
   logic [DW-1:0]     dec_dest;
   logic [DATA_W-1:0] data_q;
   logic [CW-1:0]     wait_q;
   logic              sel_ready;
   logic              accept;
   logic              drop;
   logic              inc_unm;
   logic              inc_to;

   // Scan from the top so the lowest matching index wins.
   always_comb begin
      dec_dest = DEF_PORT;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (in_pf == PORT_PF[i] && in_va == PORT_VA[i] &&
             (!PORT_VA[i] || in_vf == PORT_VF[i]))
            dec_dest = DW'(i);
      end
   end

   assign sel_ready = out_ready[dest_q];

   always_comb begin
      out_valid = '0;
      if (state_q == HOLD)
         out_valid[dest_q] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      drop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_d = HOLD;
         end
         HOLD: begin
            in_ready = sel_ready;
            drop     = TO_EN && !sel_ready && (wait_q == TO_LAST);
            if ((sel_ready && !in_valid) || drop)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign inc_unm  = accept && (dec_dest == DEF_PORT);
   assign inc_to   = drop;
   assign out_data = data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dest_q  <= '0;
         data_q  <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            dest_q <= dec_dest;
            data_q <= in_data;
            wait_q <= '0;
         end else if (drop) begin
            wait_q <= '0;
         end else if (state_q == HOLD && !sel_ready && TO_EN) begin
            wait_q <= wait_q + CW'(1);
         end
      end
   end

   // A same-cycle event beats err_clr: count restarts at 1, flag stays set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         unmatched_cnt <= '0;
         timeout_cnt   <= '0;
         err_sticky    <= 1'b0;
      end else begin
         if (err_clr)
            unmatched_cnt <= {15'd0, inc_unm};
         else if (inc_unm && unmatched_cnt != 16'hFFFF)
            unmatched_cnt <= unmatched_cnt + 16'd1;

         if (err_clr)
            timeout_cnt <= {15'd0, inc_to};
         else if (inc_to && timeout_cnt != 16'hFFFF)
            timeout_cnt <= timeout_cnt + 16'd1;

         if (inc_unm || inc_to)
            err_sticky <= 1'b1;
         else if (err_clr)
            err_sticky <= 1'b0;
      end
   end

endmodule
